alu_main: RTL and testbench

- 8-bit registered ALU with a small control FSM: Reset, Load, Persist.
- Load computes on two external operands, num1 and num2.
- Persist feeds the previous result back as operand A, so operations chain in accumulator style.
- Top-level datapath block: operand muxes, a one-hot operation select, and a registered result, with current and next state exported for observation.

---
 rtl/alu_main_pkg.sv | 21 ++
 rtl/alu_main_if.sv | 24 ++
 rtl/alu_core.sv | 28 ++
 rtl/alu_main.sv | 73 +++++++
 tb/tb_alu_main.sv | 111 +++++++++++
 5 files changed

// File: rtl/alu_main_pkg.sv
// Shared constants for the accumulator-style ALU: FSM state encoding,
// one-hot operation selects and the default datapath width.
package alu_main_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_RST     = 2'b00,
    ST_LOAD    = 2'b01,
    ST_PERSIST = 2'b10,
    ST_UNUSED  = 2'b11
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_SUB = 6'b000010;
  localparam logic [5:0] OP_AND = 6'b000100;
  localparam logic [5:0] OP_OR  = 6'b001000;
  localparam logic [5:0] OP_XOR = 6'b010000;
  localparam logic [5:0] OP_NOT = 6'b100000;

endpackage

// File: rtl/alu_main_if.sv
// Mode/operand/result bundle of the ALU; the slave side is the ALU itself.
interface alu_main_if
  import alu_main_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [2:0]       in_sel;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic [5:0]       out_sel;
  logic [WIDTH-1:0] out;
  logic [1:0]       currState;
  logic [1:0]       nextState;

  modport master (
    output in_sel, num1, num2, out_sel,
    input  out, currState, nextState
  );

  modport slave (
    input  in_sel, num1, num2, out_sel,
    output out, currState, nextState
  );
endinterface

// File: rtl/alu_core.sv
// Combinational operation unit; valid drops when op_sel is not exactly one-hot.
module alu_core
  import alu_main_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       op_sel,
  output logic [WIDTH-1:0] result,
  output logic             valid
);

  always_comb begin
    result = '0;
    valid  = 1'b1;
    case (op_sel)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_main.sv
// Registered ALU with Reset/Load/Persist control; Persist chains the previous
// result back in as operand A.
module alu_main
  import alu_main_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic       clk,
  input logic       reset,
  alu_main_if.slave bus
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] core_result;
  logic             core_valid;

  // Priority decode of the mode request; the unused encoding falls back to RST.
  always_comb begin
    state_next = state_reg;
    if (bus.in_sel[0]) begin
      state_next = ST_RST;
    end else if (bus.in_sel[1]) begin
      state_next = ST_LOAD;
    end else if (bus.in_sel[2]) begin
      state_next = ST_PERSIST;
    end else if (state_reg == ST_UNUSED) begin
      state_next = ST_RST;
    end
  end

  assign operand_a = (state_next == ST_PERSIST) ? out_reg : bus.num1;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (operand_a),
    .b      (bus.num2),
    .op_sel (bus.out_sel),
    .result (core_result),
    .valid  (core_valid)
  );

  always_comb begin
    out_next = out_reg;
    case (state_next)
      ST_LOAD, ST_PERSIST: begin
        if (core_valid) begin
          out_next = core_result;
        end
      end
      default: out_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_RST;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
    end
  end

  assign bus.out       = out_reg;
  assign bus.currState = state_reg;
  assign bus.nextState = state_next;

endmodule

// File: tb/tb_alu_main.sv
// Directed bench for alu_main: reset, per-op loads, persist chaining, priority,
// hold, invalid selects and mid-chain reset, against hand-computed values.
module tb_alu_main;
  import alu_main_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  alu_main_if #(.WIDTH(8)) bus ();

  alu_main #(
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive inputs on the falling edge so they are stable well before the rising edge.
  task automatic drive(input logic rst, input logic [2:0] sel, input logic [7:0] n1,
                       input logic [7:0] n2, input logic [5:0] op);
    @(negedge clk);
    reset       = rst;
    bus.in_sel  = sel;
    bus.num1    = n1;
    bus.num2    = n2;
    bus.out_sel = op;
    #1;
  endtask

  task automatic step_check(input string tag, input logic [1:0] exp_state, input logic [7:0] exp_out);
    @(posedge clk);
    #1;
    check({tag, "_state"}, {6'd0, bus.currState}, {6'd0, exp_state});
    check({tag, "_out"}, bus.out, exp_out);
    $display("step %-12s state=%b out=%h", tag, bus.currState, bus.out);
  endtask

  initial begin
    reset       = 1'b1;
    bus.in_sel  = 3'b000;
    bus.num1    = 8'h00;
    bus.num2    = 8'h00;
    bus.out_sel = 6'b000000;

    // Reset overrides a load request; nextState still follows in_sel.
    drive(1'b1, 3'b010, 8'hC3, 8'h3C, OP_ADD);
    check("rst_next", {6'd0, bus.nextState}, 8'h01);
    step_check("reset", 2'b00, 8'h00);

    // Load, one op per cycle on 57/1A.
    drive(1'b0, 3'b010, 8'h57, 8'h1A, OP_ADD); step_check("ld_add", 2'b01, 8'h71);
    drive(1'b0, 3'b010, 8'h57, 8'h1A, OP_SUB); step_check("ld_sub", 2'b01, 8'h3D);
    drive(1'b0, 3'b010, 8'h57, 8'h1A, OP_AND); step_check("ld_and", 2'b01, 8'h12);
    drive(1'b0, 3'b010, 8'h57, 8'h1A, OP_OR);  step_check("ld_or",  2'b01, 8'h5F);
    drive(1'b0, 3'b010, 8'h57, 8'h1A, OP_XOR); step_check("ld_xor", 2'b01, 8'h4D);
    drive(1'b0, 3'b010, 8'h57, 8'h1A, OP_NOT); step_check("ld_not", 2'b01, 8'hA8);

    // Persist chain.
    drive(1'b0, 3'b010, 8'h57, 8'h1A, OP_ADD); step_check("ld_add2", 2'b01, 8'h71);
    drive(1'b0, 3'b100, 8'hEE, 8'h1A, OP_ADD); step_check("ps_add1", 2'b10, 8'h8B);
    drive(1'b0, 3'b100, 8'hEE, 8'h1A, OP_ADD); step_check("ps_add2", 2'b10, 8'hA5);

    // Wrap-around.
    drive(1'b0, 3'b010, 8'hFF, 8'h01, OP_ADD); step_check("wrap_add", 2'b01, 8'h00);
    drive(1'b0, 3'b010, 8'h00, 8'h01, OP_SUB); step_check("wrap_sub", 2'b01, 8'hFF);

    // Priority.
    drive(1'b0, 3'b111, 8'h57, 8'h1A, OP_ADD);
    check("pri111_next", {6'd0, bus.nextState}, 8'h00);
    step_check("pri111", 2'b00, 8'h00);
    drive(1'b0, 3'b110, 8'h57, 8'h1A, OP_ADD);
    check("pri110_next", {6'd0, bus.nextState}, 8'h01);
    step_check("pri110", 2'b01, 8'h71);

    // Invalid op selects hold out while the state follows in_sel.
    drive(1'b0, 3'b010, 8'h10, 8'h20, 6'b000000); step_check("inv_zero", 2'b01, 8'h71);
    drive(1'b0, 3'b100, 8'h10, 8'h20, 6'b000011); step_check("inv_multi", 2'b10, 8'h71);

    // Hold in PERSIST keeps accumulating.
    drive(1'b0, 3'b100, 8'h00, 8'h1A, OP_ADD); step_check("ps_add3", 2'b10, 8'h8B);
    drive(1'b0, 3'b000, 8'h00, 8'h01, OP_ADD);
    check("hold_next", {6'd0, bus.nextState}, 8'h02);
    step_check("hold1", 2'b10, 8'h8C);
    drive(1'b0, 3'b000, 8'h00, 8'h0F, OP_AND); step_check("hold2", 2'b10, 8'h0C);

    // Reset mid-chain, then persist from zero.
    drive(1'b1, 3'b100, 8'h00, 8'h05, OP_ADD); step_check("mid_rst", 2'b00, 8'h00);
    drive(1'b0, 3'b100, 8'h99, 8'h05, OP_ADD); step_check("after_rst", 2'b10, 8'h05);

    // Reset request via in_sel, hold in RST, then persist chains from 0.
    drive(1'b0, 3'b001, 8'h99, 8'h05, OP_ADD); step_check("req_rst", 2'b00, 8'h00);
    drive(1'b0, 3'b000, 8'h99, 8'h05, OP_ADD); step_check("hold_rst", 2'b00, 8'h00);
    drive(1'b0, 3'b100, 8'h99, 8'h3C, OP_XOR); step_check("ps_xor", 2'b10, 8'h3C);
    drive(1'b0, 3'b100, 8'h99, 8'h0F, OP_NOT); step_check("ps_not", 2'b10, 8'hC3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
